// File: rtl/pwm_mixer_n.sv
// pwm_mixer_n: N-channel quadrature encoder to PWM mixer with shared counter.
// Optional PWM_MIXER_SHADOW_EN: compare against a period-aligned shadow level.
module pwm_mixer_n #(
  parameter int NUM_CH  = 3,
  parameter int WIDTH   = 8,
  parameter int DEB_LEN = 4,
  parameter int STEP    = 1,
  parameter int WRAP    = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       enc_a,
  input  logic [NUM_CH-1:0]       enc_b,
  output logic [NUM_CH-1:0]       pwm_out,
  output logic [NUM_CH*WIDTH-1:0] level
);

  localparam logic [WIDTH:0]   STEP_W  = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] LVL_MAX = '1;

  logic [NUM_CH-1:0]  a_s1_q, a_s1_d, a_s2_q, a_s2_d;
  logic [NUM_CH-1:0]  b_s1_q, b_s1_d, b_s2_q, b_s2_d;
  logic [DEB_LEN-2:0] a_hist_q [NUM_CH];
  logic [DEB_LEN-2:0] a_hist_d [NUM_CH];
  logic [DEB_LEN-2:0] b_hist_q [NUM_CH];
  logic [DEB_LEN-2:0] b_hist_d [NUM_CH];
  logic [DEB_LEN-1:0] a_win    [NUM_CH];
  logic [DEB_LEN-1:0] b_win    [NUM_CH];
  logic [NUM_CH-1:0]  deb_a_q, deb_a_d, deb_b_q, deb_b_d;
  logic [NUM_CH-1:0]  prev_a_q, prev_a_d;
  logic [WIDTH-1:0]   lvl_q    [NUM_CH];
  logic [WIDTH-1:0]   lvl_d    [NUM_CH];
  logic [WIDTH-1:0]   lvl_eff  [NUM_CH];
  logic [WIDTH:0]     sum      [NUM_CH];
  logic [WIDTH:0]     dif      [NUM_CH];
  logic [WIDTH-1:0]   cnt_q, cnt_d;
  logic [NUM_CH-1:0]  pwm_q, pwm_d;

  // two-stage synchronisers and debounce windows (history + newest sample)
  always_comb begin
    a_s1_d  = enc_a;
    b_s1_d  = enc_b;
    a_s2_d  = a_s1_q;
    b_s2_d  = b_s1_q;
    deb_a_d = deb_a_q;
    deb_b_d = deb_b_q;
    for (int i = 0; i < NUM_CH; i++) begin
      a_win[i]    = {a_hist_q[i], a_s2_q[i]};
      b_win[i]    = {b_hist_q[i], b_s2_q[i]};
      a_hist_d[i] = a_win[i][DEB_LEN-2:0];
      b_hist_d[i] = b_win[i][DEB_LEN-2:0];
      if (&a_win[i])       deb_a_d[i] = 1'b1;
      else if (~|a_win[i]) deb_a_d[i] = 1'b0;
      if (&b_win[i])       deb_b_d[i] = 1'b1;
      else if (~|b_win[i]) deb_b_d[i] = 1'b0;
    end
  end

  // one count per A rising edge, direction from B, saturate or wrap
  always_comb begin
    prev_a_d = deb_a_q;
    for (int i = 0; i < NUM_CH; i++) begin
      sum[i]   = {1'b0, lvl_q[i]} + STEP_W;
      dif[i]   = {1'b0, lvl_q[i]} - STEP_W;
      lvl_d[i] = lvl_q[i];
      if (deb_a_q[i] && !prev_a_q[i]) begin
        if (deb_b_q[i]) begin
          if (WRAP != 0)        lvl_d[i] = dif[i][WIDTH-1:0];
          else if (dif[i][WIDTH]) lvl_d[i] = '0;
          else                  lvl_d[i] = dif[i][WIDTH-1:0];
        end else begin
          if (WRAP != 0)        lvl_d[i] = sum[i][WIDTH-1:0];
          else if (sum[i][WIDTH]) lvl_d[i] = LVL_MAX;
          else                  lvl_d[i] = sum[i][WIDTH-1:0];
        end
      end
    end
  end

`ifdef PWM_MIXER_SHADOW_EN
  logic [WIDTH-1:0] shd_q [NUM_CH];
  logic [WIDTH-1:0] shd_d [NUM_CH];

  // reload shadow on the last count so new levels start a fresh period
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      shd_d[i]   = (cnt_q == LVL_MAX) ? lvl_q[i] : shd_q[i];
      lvl_eff[i] = shd_q[i];
    end
  end

  // shadow level registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) shd_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) shd_q[i] <= shd_d[i];
    end
  end
`else
  // live compare against the current level
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) lvl_eff[i] = lvl_q[i];
  end
`endif

  // shared free-running counter and registered compare
  always_comb begin
    cnt_d = cnt_q + WIDTH'(1);
    for (int i = 0; i < NUM_CH; i++) pwm_d[i] = (cnt_q < lvl_eff[i]);
  end

  // state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_s1_q   <= '0;
      a_s2_q   <= '0;
      b_s1_q   <= '0;
      b_s2_q   <= '0;
      deb_a_q  <= '0;
      deb_b_q  <= '0;
      prev_a_q <= '0;
      cnt_q    <= '0;
      pwm_q    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        a_hist_q[i] <= '0;
        b_hist_q[i] <= '0;
        lvl_q[i]    <= '0;
      end
    end else begin
      a_s1_q   <= a_s1_d;
      a_s2_q   <= a_s2_d;
      b_s1_q   <= b_s1_d;
      b_s2_q   <= b_s2_d;
      deb_a_q  <= deb_a_d;
      deb_b_q  <= deb_b_d;
      prev_a_q <= prev_a_d;
      cnt_q    <= cnt_d;
      pwm_q    <= pwm_d;
      for (int i = 0; i < NUM_CH; i++) begin
        a_hist_q[i] <= a_hist_d[i];
        b_hist_q[i] <= b_hist_d[i];
        lvl_q[i]    <= lvl_d[i];
      end
    end
  end

  // pack outputs
  always_comb begin
    pwm_out = pwm_q;
    level   = '0;
    for (int i = 0; i < NUM_CH; i++) level[i*WIDTH +: WIDTH] = lvl_q[i];
  end

endmodule

// File: tb/tb_pwm_mixer_n.sv
// tb_pwm_mixer_n: randomized scoreboard bench for pwm_mixer_n.
// Two instances: saturating 3ch/8bit and wrapping 2ch/4bit step 3.
module tb_pwm_mixer_n;

  localparam int D0 = 4;
  localparam int D1 = 3;
`ifdef PWM_MIXER_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  typedef struct {
    int          cyc;
    logic [23:0] v;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  a0 = '0, b0 = '0, pwm0;
  logic [23:0] level0;
  logic [1:0]  a1 = '0, b1 = '0, pwm1;
  logic [7:0]  level1;

  ev_t q0[$], q1[$], s0[$], s1[$];
  ev_t me, pe;
  int  cm0[3], cm1[2], ml0[3], ml1[2], sh0[3], sh1[2];
  int  hc0[3], mc0[3], ec0[3], hc1[2], mc1[2], ec1[2];
  logic [2:0]  ep0;
  logic [1:0]  ep1;
  logic [23:0] last0;
  logic [7:0]  last1;
  int  cyc = 0, rel0 = 0, checks = 0, errors = 0, mph = 0, eff = 0;
  bit  run = 1'b0;

  always #5 clk = ~clk;

  pwm_mixer_n #(
    .NUM_CH(3), .WIDTH(8), .DEB_LEN(D0), .STEP(1), .WRAP(0)
  ) u0 (
    .clk(clk), .reset(reset), .enc_a(a0), .enc_b(b0),
    .pwm_out(pwm0), .level(level0)
  );

  pwm_mixer_n #(
    .NUM_CH(2), .WIDTH(4), .DEB_LEN(D1), .STEP(3), .WRAP(1)
  ) u1 (
    .clk(clk), .reset(reset), .enc_a(a1), .enc_b(b1),
    .pwm_out(pwm1), .level(level1)
  );

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic int nxt(int l, bit ccw, int st, int w, bit wrap);
    int p = 1 << w;
    int r = ccw ? l - st : l + st;
    if (wrap) r = ((r % p) + p) % p;
    else if (r < 0) r = 0;
    else if (r > p - 1) r = p - 1;
    return r;
  endfunction

  function automatic logic [23:0] vec0();
    logic [23:0] v = '0;
    for (int i = 0; i < 3; i++) v[i*8 +: 8] = 8'(cm0[i]);
    return v;
  endfunction

  function automatic logic [23:0] vec1();
    logic [23:0] v = '0;
    for (int i = 0; i < 2; i++) v[i*4 +: 4] = 4'(cm1[i]);
    return v;
  endfunction

  // reference timeline: phase from cycles since release, levels by schedule
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      ep0 = '0;
      ep1 = '0;
      for (int i = 0; i < 3; i++) begin ml0[i] = 0; sh0[i] = 0; end
      for (int i = 0; i < 2; i++) begin ml1[i] = 0; sh1[i] = 0; end
    end else if (run) begin
      mph = cyc - rel0 - 1;
      for (int i = 0; i < 3; i++) begin
        eff = SHADOW ? sh0[i] : ml0[i];
        ep0[i] = ((mph % 256) < eff);
        if (SHADOW && (mph % 256) == 255) sh0[i] = ml0[i];
      end
      for (int i = 0; i < 2; i++) begin
        eff = SHADOW ? sh1[i] : ml1[i];
        ep1[i] = ((mph % 16) < eff);
        if (SHADOW && (mph % 16) == 15) sh1[i] = ml1[i];
      end
      while (s0.size() > 0 && s0[0].cyc == cyc) begin
        pe = s0.pop_front();
        for (int i = 0; i < 3; i++) ml0[i] = int'(pe.v[i*8 +: 8]);
      end
      while (s1.size() > 0 && s1[0].cyc == cyc) begin
        pe = s1.pop_front();
        for (int i = 0; i < 2; i++) ml1[i] = int'(pe.v[i*4 +: 4]);
      end
    end
  end

  // monitor: level events against scoreboard, pwm per 256-cycle period
  always @(negedge clk) begin
    if (reset) begin
      last0 = level0;
      last1 = level1;
      for (int i = 0; i < 3; i++) begin hc0[i] = 0; mc0[i] = 0; ec0[i] = 0; end
      for (int i = 0; i < 2; i++) begin hc1[i] = 0; mc1[i] = 0; ec1[i] = 0; end
    end else if (run && cyc > rel0) begin
      if (level0 !== last0) begin
        if (q0.size() == 0) chk("lvl0_unexpected", 32'(level0), 32'(last0));
        else begin
          me = q0.pop_front();
          chk("lvl0_value", 32'(level0), 32'(me.v));
          chk("lvl0_cycle", cyc, me.cyc);
        end
        last0 = level0;
      end else if (q0.size() > 0 && cyc > q0[0].cyc) begin
        me = q0.pop_front();
        chk("lvl0_missed", 32'(level0), 32'(me.v));
      end
      if (level1 !== last1) begin
        if (q1.size() == 0) chk("lvl1_unexpected", 32'(level1), 32'(last1));
        else begin
          me = q1.pop_front();
          chk("lvl1_value", 32'(level1), 32'(me.v[7:0]));
          chk("lvl1_cycle", cyc, me.cyc);
        end
        last1 = level1;
      end else if (q1.size() > 0 && cyc > q1[0].cyc) begin
        me = q1.pop_front();
        chk("lvl1_missed", 32'(level1), 32'(me.v[7:0]));
      end
      for (int i = 0; i < 3; i++) begin
        hc0[i] += int'(pwm0[i]);
        ec0[i] += int'(ep0[i]);
        if (pwm0[i] !== ep0[i]) mc0[i]++;
      end
      for (int i = 0; i < 2; i++) begin
        hc1[i] += int'(pwm1[i]);
        ec1[i] += int'(ep1[i]);
        if (pwm1[i] !== ep1[i]) mc1[i]++;
      end
      if (((cyc - rel0 - 1) % 256) == 255) begin
        for (int i = 0; i < 3; i++) begin
          chk($sformatf("pwm0_ch%0d_highs", i), hc0[i], ec0[i]);
          chk($sformatf("pwm0_ch%0d_pos", i), mc0[i], 0);
          hc0[i] = 0; mc0[i] = 0; ec0[i] = 0;
        end
        for (int i = 0; i < 2; i++) begin
          chk($sformatf("pwm1_ch%0d_highs", i), hc1[i], ec1[i]);
          chk($sformatf("pwm1_ch%0d_pos", i), mc1[i], 0);
          hc1[i] = 0; mc1[i] = 0; ec1[i] = 0;
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #2;
    a0 = 3'($urandom); b0 = 3'($urandom);
    a1 = 2'($urandom); b1 = 2'($urandom);
    reset = 1'b1;
    #1;
    chk("rst_level0", 32'(level0), 32'h0);
    chk("rst_level1", 32'(level1), 32'h0);
    chk("rst_pwm0", 32'(pwm0), 32'h0);
    chk("rst_pwm1", 32'(pwm1), 32'h0);
    q0.delete(); q1.delete(); s0.delete(); s1.delete();
    for (int i = 0; i < 3; i++) cm0[i] = 0;
    for (int i = 0; i < 2; i++) cm1[i] = 0;
    repeat (2) @(negedge clk);
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b0;
    rel0  = cyc;
    run   = 1'b1;
  endtask

  task automatic detent(input logic [2:0] m0, input logic [1:0] m1,
                        input bit ccw, input int hi);
    logic [23:0] o0, o1;
    ev_t e;
    @(negedge clk);
    for (int i = 0; i < 3; i++) if (m0[i]) b0[i] = ccw;
    for (int i = 0; i < 2; i++) if (m1[i]) b1[i] = ccw;
    repeat (2) @(negedge clk);
    o0 = vec0();
    o1 = vec1();
    if (hi >= D0)
      for (int i = 0; i < 3; i++) if (m0[i]) cm0[i] = nxt(cm0[i], ccw, 1, 8, 1'b0);
    if (hi >= D1)
      for (int i = 0; i < 2; i++) if (m1[i]) cm1[i] = nxt(cm1[i], ccw, 3, 4, 1'b1);
    e.cyc = cyc + D0 + 3;
    e.v   = vec0();
    if (e.v != o0) begin q0.push_back(e); s0.push_back(e); end
    e.cyc = cyc + D1 + 3;
    e.v   = vec1();
    if (e.v != o1) begin q1.push_back(e); s1.push_back(e); end
    a0 = a0 | m0;
    a1 = a1 | m1;
    repeat (hi) @(negedge clk);
    a0 = a0 & ~m0;
    a1 = a1 & ~m1;
    repeat (D0 + 6) @(negedge clk);
  endtask

  task automatic bounce(input logic [2:0] m0, input logic [1:0] m1);
    for (int k = 1; k < D0; k++) begin
      a0 = a0 | m0;
      if (k < D1) a1 = a1 | m1;
      repeat (k) @(negedge clk);
      a0 = a0 & ~m0;
      a1 = a1 & ~m1;
      @(negedge clk);
    end
    repeat (D0 + 6) @(negedge clk);
  endtask

  task automatic chk_all(input string nm);
    chk({nm, "_l0"}, 32'(level0), 32'(vec0()));
    chk({nm, "_l1"}, 32'(level1), 32'(vec1()));
  endtask

  initial begin
    do_reset();

    repeat (5) detent(3'b101, 2'b10, 1'b0, D0 + 1);
    chk("cw5_ch0", 32'(level0[7:0]), 32'd5);
    chk("cw5_ch1", 32'(level0[15:8]), 32'd0);
    chk("cw5_ch2", 32'(level0[23:16]), 32'd5);
    chk("cw5_u1", 32'(level1), 32'hf0);

    bounce(3'b111, 2'b11);
    chk_all("bounce");

    for (int n = 0; n < 260; n++)
      detent({n < 59, 1'b0, 1'b1}, 2'b01, 1'b0, D0);
    chk("sat_hi", 32'(level0[7:0]), 32'd255);
    chk("lvl64", 32'(level0[23:16]), 32'd64);
    chk("wrap_u1_ch0", 32'(level1[3:0]), 32'd12);
    repeat (600) @(negedge clk);

    detent(3'b011, 2'b01, 1'b1, D0);
    chk("sat_dn", 32'(level0[7:0]), 32'd254);
    chk("sat_lo", 32'(level0[15:8]), 32'd0);
    chk("u1_ccw", 32'(level1[3:0]), 32'd9);
    detent(3'b000, 2'b10, 1'b0, D0);
    chk("u1_wrap_up", 32'(level1[7:4]), 32'd2);
    detent(3'b000, 2'b10, 1'b1, D0);
    chk("u1_wrap_dn", 32'(level1[7:4]), 32'd15);

    while (((cyc + 10 - rel0) % 256) != 100) @(negedge clk);
    detent(3'b100, 2'b00, 1'b0, D0);
    repeat (600) @(negedge clk);
    chk_all("midper");

    repeat (120) begin
      if ($urandom_range(0, 7) == 0)
        bounce(3'($urandom), 2'($urandom));
      else
        detent(3'($urandom), 2'($urandom), 1'($urandom),
               $urandom_range(1, 6));
    end
    repeat (300) @(negedge clk);
    chk_all("random");

    detent(3'b111, 2'b11, 1'b0, D0);
    repeat (20) @(negedge clk);
    do_reset();
    repeat (3) detent(3'b111, 2'b11, 1'b0, D0);
    repeat (600) @(negedge clk);
    chk_all("post_rst");
    chk("q0_empty", q0.size(), 0);
    chk("q1_empty", q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
